// File: rtl/load_align_unit_pkg.sv
// load_align_unit_pkg: load opcodes, region codes, FSM encodings and decode helpers
// shared by the load alignment unit and its lane-extension sub-block.
`default_nettype none

package load_align_unit_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_DMEM = 2'd1,
    REGION_BIOS = 2'd2,
    REGION_IO   = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_SPLIT = 2'd2
  } state_t;

  function automatic region_t decode_region(input logic [3:0] top);
    case (top)
      4'b0001, 4'b0011: decode_region = REGION_DMEM;
      4'b0100:          decode_region = REGION_BIOS;
      4'b1000:          decode_region = REGION_IO;
      default:          decode_region = REGION_NONE;
    endcase
  endfunction

  // A load crosses a word boundary when its last byte lands in the next word.
  function automatic logic is_crossing(input logic [2:0] fnc, input logic [1:0] off);
    is_crossing = (((fnc == FNC_LH) || (fnc == FNC_LHU)) && (off == 2'd3)) ||
                  ((fnc == FNC_LW) && (off != 2'd0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align_unit_if.sv
// load_align_unit_if: MEM-stage load request, memory read ports and writeback result.
`default_nettype none

interface load_align_unit_if;
  logic        req_valid;
  logic [2:0]  fnc;
  logic [31:0] addr;
  logic [31:0] mem_addr;
  logic        dmem_re;
  logic        bios_re;
  logic        io_re;
  logic [31:0] dmem_rdata;
  logic [31:0] bios_rdata;
  logic [31:0] io_rdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_misaligned;

  modport slave (
    input  req_valid, fnc, addr, dmem_rdata, bios_rdata, io_rdata,
    output mem_addr, dmem_re, bios_re, io_re, stall, ld_valid, ld_data, ld_misaligned
  );

  modport master (
    output req_valid, fnc, addr, dmem_rdata, bios_rdata, io_rdata,
    input  mem_addr, dmem_re, bios_re, io_re, stall, ld_valid, ld_data, ld_misaligned
  );
endinterface

`default_nettype wire

// File: rtl/load_extend.sv
// load_extend: selects the byte/half/word starting at offset within a {word1, word0}
// window and sign- or zero-extends it to 32 bits.
`default_nettype none

module load_extend
  import load_align_unit_pkg::*;
(
  input  wire logic [2:0]  fnc,
  input  wire logic [1:0]  offset,
  input  wire logic [63:0] window,
  output logic      [31:0] result
);

  logic [31:0] lanes;

  always_comb begin
    lanes  = window[{offset, 3'b000} +: 32];
    result = 32'd0;
    case (fnc)
      FNC_LB:  result = {{24{lanes[7]}}, lanes[7:0]};
      FNC_LH:  result = {{16{lanes[15]}}, lanes[15:0]};
      FNC_LW:  result = lanes;
      FNC_LBU: result = {24'd0, lanes[7:0]};
      FNC_LHU: result = {16'd0, lanes[15:0]};
      default: result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_align_unit.sv
// load_align_unit: MEM-stage load path - region-decoded word reads, 1-cycle response,
// lane extraction/extension. MISALIGNED_LOAD_EN enables two-read word-crossing loads.
`default_nettype none

module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input wire logic clk,
  input wire logic rst,
  load_align_unit_if.slave bus
);

  state_t               state, state_nx;
  region_t              req_region, rd_region, cap_region;
  logic [2:0]           cap_fnc;
  logic [1:0]           cap_off, ext_off;
  logic [AWIDTH-1:0]    word_addr, mem_addr;
  logic [DWIDTH-1:0]    sel_rdata, ext_out;
  logic [63:0]          window;
  logic                 accept, crossing, cap_crossing, stall, ld_valid;
`ifdef MISALIGNED_LOAD_EN
  logic [29:0]          cap_word;
  logic [31:0]          word0;
`endif

  assign req_region   = decode_region(bus.addr[31:28]);
  assign crossing     = is_crossing(bus.fnc, bus.addr[1:0]);
  assign cap_crossing = is_crossing(cap_fnc, cap_off);
  assign word_addr    = {bus.addr[31:2], 2'b00};
  assign accept       = bus.req_valid && !rst && ((state == ST_IDLE) || (state == ST_RESP));

  always_comb begin
    state_nx  = state;
    rd_region = REGION_NONE;
    mem_addr  = word_addr;
    stall     = 1'b0;
    ld_valid  = 1'b0;
    case (state)
      ST_IDLE, ST_RESP: begin
        ld_valid = (state == ST_RESP);
        state_nx = ST_IDLE;
        if (accept) begin
          rd_region = req_region;
          state_nx  = ST_RESP;
`ifdef MISALIGNED_LOAD_EN
          if (crossing) begin
            state_nx = ST_SPLIT;
            stall    = 1'b1;
          end
`endif
        end
      end
      ST_SPLIT: begin
`ifdef MISALIGNED_LOAD_EN
        // Second word: wraps naturally at the top of the 32-bit space.
        mem_addr  = {cap_word + 30'd1, 2'b00};
        rd_region = cap_region;
        state_nx  = ST_RESP;
`else
        state_nx  = ST_IDLE;
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cap_fnc    <= 3'd0;
      cap_off    <= 2'd0;
      cap_region <= REGION_NONE;
`ifdef MISALIGNED_LOAD_EN
      cap_word   <= 30'd0;
      word0      <= 32'd0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        cap_fnc    <= bus.fnc;
        cap_off    <= bus.addr[1:0];
        cap_region <= req_region;
`ifdef MISALIGNED_LOAD_EN
        cap_word   <= bus.addr[31:2];
`endif
      end
`ifdef MISALIGNED_LOAD_EN
      if (state == ST_SPLIT) word0 <= sel_rdata;
`endif
    end
  end

  always_comb begin
    case (cap_region)
      REGION_DMEM: sel_rdata = bus.dmem_rdata;
      REGION_BIOS: sel_rdata = bus.bios_rdata;
      REGION_IO:   sel_rdata = bus.io_rdata;
      default:     sel_rdata = '0;
    endcase
  end

`ifdef MISALIGNED_LOAD_EN
  assign window  = cap_crossing ? {sel_rdata, word0} : {32'd0, sel_rdata};
  assign ext_off = cap_off;
  assign bus.ld_misaligned = 1'b0;
`else
  // Without split support a crossing load is served from its own word only.
  assign window  = {32'd0, sel_rdata};
  assign ext_off = cap_crossing ? ((cap_fnc == FNC_LW) ? 2'd0 : 2'd2) : cap_off;
  assign bus.ld_misaligned = ld_valid && cap_crossing;
`endif

  load_extend u_load_extend (
    .fnc    (cap_fnc),
    .offset (ext_off),
    .window (window),
    .result (ext_out)
  );

  assign bus.mem_addr = mem_addr;
  assign bus.dmem_re  = !rst && (rd_region == REGION_DMEM);
  assign bus.bios_re  = !rst && (rd_region == REGION_BIOS);
  assign bus.io_re    = !rst && (rd_region == REGION_IO);
  assign bus.stall    = stall;
  assign bus.ld_valid = ld_valid;
  assign bus.ld_data  = ld_valid ? ext_out : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed vector table plus hand-written multi-cycle sequences.
`default_nettype none

module tb_load_align_unit;
  import load_align_unit_pkg::*;

  localparam logic [31:0] BIOS_WORD = 32'hCAFEF00D;
  localparam logic [31:0] IO_WORD   = 32'hF0DA7A00;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  load_align_unit_if bus();

  load_align_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dmem_word(input logic [31:0] a);
    case (a)
      32'h10000000: dmem_word = 32'h8899AABB;
      32'h10000004: dmem_word = 32'h11223344;
      default:      dmem_word = ~a;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (bus.dmem_re) bus.dmem_rdata <= dmem_word(bus.mem_addr);
    if (bus.bios_re) bus.bios_rdata <= BIOS_WORD;
    if (bus.io_re)   bus.io_rdata   <= IO_WORD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a);
    bus.req_valid = v;
    bus.fnc       = f;
    bus.addr      = a;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  fnc;
    logic [31:0] addr;
    logic [31:0] exp_maddr;
    logic [2:0]  exp_re;    // {dmem, bios, io}
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{FNC_LB,  32'h10000001, 32'h10000000, 3'b100, 32'hFFFFFFAA};
    vecs[1]  = '{FNC_LBU, 32'h10000001, 32'h10000000, 3'b100, 32'h000000AA};
    vecs[2]  = '{FNC_LH,  32'h10000002, 32'h10000000, 3'b100, 32'hFFFF8899};
    vecs[3]  = '{FNC_LHU, 32'h10000000, 32'h10000000, 3'b100, 32'h0000AABB};
    vecs[4]  = '{FNC_LW,  32'h10000004, 32'h10000004, 3'b100, 32'h11223344};
    vecs[5]  = '{FNC_LB,  32'h10000007, 32'h10000004, 3'b100, 32'h00000011};
    vecs[6]  = '{FNC_LW,  32'h40000000, 32'h40000000, 3'b010, 32'hCAFEF00D};
    vecs[7]  = '{FNC_LB,  32'h80000003, 32'h80000000, 3'b001, 32'hFFFFFFF0};
    vecs[8]  = '{FNC_LW,  32'h20000000, 32'h20000000, 3'b000, 32'h00000000};
    vecs[9]  = '{3'b011,  32'h10000000, 32'h10000000, 3'b100, 32'h00000000};
    vecs[10] = '{FNC_LW,  32'h30000008, 32'h30000008, 3'b100, 32'hCFFFFFF7};
    vecs[11] = '{FNC_LHU, 32'h4000000A, 32'h40000008, 3'b010, 32'h0000CAFE};
    vecs[12] = '{FNC_LH,  32'h10000001, 32'h10000000, 3'b100, 32'hFFFF99AA};

    // Reset, including a simultaneous request that must not strobe.
    rst = 1'b1;
    drive(1'b1, FNC_LW, 32'h10000000);
    #2;
    chk("rst_dmem_re", {31'd0, bus.dmem_re}, 32'd0);
    chk("rst_ld_valid", {31'd0, bus.ld_valid}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_ld_data", bus.ld_data, 32'd0);
    chk("rst_misaligned", {31'd0, bus.ld_misaligned}, 32'd0);
    edge1();
    edge1();
    chk("rst_hold_ld_valid", {31'd0, bus.ld_valid}, 32'd0);
    drive(1'b0, FNC_LW, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      edge1();
      drive(1'b1, vecs[i].fnc, vecs[i].addr);
      #1;
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].exp_maddr);
      chk($sformatf("v%0d_re", i), {29'd0, bus.dmem_re, bus.bios_re, bus.io_re},
          {29'd0, vecs[i].exp_re});
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall}, 32'd0);
      edge1();
      drive(1'b0, 3'd0, 32'h0);
      #1;
      chk($sformatf("v%0d_ld_valid", i), {31'd0, bus.ld_valid}, 32'd1);
      chk($sformatf("v%0d_ld_data", i), bus.ld_data, vecs[i].exp_data);
      chk($sformatf("v%0d_misaligned", i), {31'd0, bus.ld_misaligned}, 32'd0);
    end

    // Back-to-back loads at one per cycle.
    edge1();
    drive(1'b1, FNC_LHU, 32'h10000001);
    edge1();
    drive(1'b1, FNC_LW, 32'h10000004);
    #1;
    chk("b2b_first_valid", {31'd0, bus.ld_valid}, 32'd1);
    chk("b2b_first_data", bus.ld_data, 32'h000099AA);
    chk("b2b_second_addr", bus.mem_addr, 32'h10000004);
    chk("b2b_second_re", {31'd0, bus.dmem_re}, 32'd1);
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    #1;
    chk("b2b_second_valid", {31'd0, bus.ld_valid}, 32'd1);
    chk("b2b_second_data", bus.ld_data, 32'h11223344);
    edge1();
    chk("b2b_idle_valid", {31'd0, bus.ld_valid}, 32'd0);

`ifdef MISALIGNED_LOAD_EN
    // Crossing LW: two reads, one stall cycle, request held during SPLIT.
    drive(1'b1, FNC_LW, 32'h10000002);
    #1;
    chk("xw_addr0", bus.mem_addr, 32'h10000000);
    chk("xw_stall0", {31'd0, bus.stall}, 32'd1);
    edge1();
    chk("xw_addr1", bus.mem_addr, 32'h10000004);
    chk("xw_re1", {31'd0, bus.dmem_re}, 32'd1);
    chk("xw_stall1", {31'd0, bus.stall}, 32'd0);
    chk("xw_valid1", {31'd0, bus.ld_valid}, 32'd0);
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    #1;
    chk("xw_valid2", {31'd0, bus.ld_valid}, 32'd1);
    chk("xw_data", bus.ld_data, 32'h33448899);
    chk("xw_mis", {31'd0, bus.ld_misaligned}, 32'd0);

    edge1();
    drive(1'b1, FNC_LH, 32'h10000003);
    #1;
    chk("xh_stall0", {31'd0, bus.stall}, 32'd1);
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    edge1();
    chk("xh_data", bus.ld_data, 32'h00004488);

    // Reset while a split is in flight abandons it.
    edge1();
    drive(1'b1, FNC_LW, 32'h10000002);
    #1;
    chk("rs_stall_pre", {31'd0, bus.stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_stall_acc", {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    edge1();
    chk("rs_split_after_acc_valid", {31'd0, bus.ld_valid}, 32'd1);
    edge1();
    drive(1'b1, FNC_LW, 32'h10000002);
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    rst = 1'b1;
    #1;
    chk("rs_split_stall", {31'd0, bus.stall}, 32'd0);
    chk("rs_split_re", {31'd0, bus.dmem_re}, 32'd0);
    edge1();
    chk("rs_split_valid", {31'd0, bus.ld_valid}, 32'd0);
    rst = 1'b0;
`else
    // Crossing loads are truncated to their own word and flagged.
    drive(1'b1, FNC_LW, 32'h10000002);
    #1;
    chk("xw_addr0", bus.mem_addr, 32'h10000000);
    chk("xw_stall0", {31'd0, bus.stall}, 32'd0);
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    #1;
    chk("xw_valid", {31'd0, bus.ld_valid}, 32'd1);
    chk("xw_data", bus.ld_data, 32'h8899AABB);
    chk("xw_mis", {31'd0, bus.ld_misaligned}, 32'd1);

    edge1();
    drive(1'b1, FNC_LH, 32'h10000003);
    #1;
    chk("xh_stall0", {31'd0, bus.stall}, 32'd0);
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    #1;
    chk("xh_data", bus.ld_data, 32'hFFFF8899);
    chk("xh_mis", {31'd0, bus.ld_misaligned}, 32'd1);

    // Reset during the response cycle drops ld_valid at once.
    edge1();
    drive(1'b1, FNC_LW, 32'h10000000);
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    rst = 1'b1;
    #1;
    chk("rs_resp_valid", {31'd0, bus.ld_valid}, 32'd0);
    chk("rs_resp_data", bus.ld_data, 32'd0);
    edge1();
    rst = 1'b0;
`endif

    // Normal operation after reset release.
    edge1();
    drive(1'b1, FNC_LW, 32'h10000000);
    edge1();
    drive(1'b0, 3'd0, 32'h0);
    #1;
    chk("post_rst_valid", {31'd0, bus.ld_valid}, 32'd1);
    chk("post_rst_data", bus.ld_data, 32'h8899AABB);

    edge1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
